// File: rtl/fft_stream_io_if.sv
// Stream, FFT-core control and data-memory signals of fft_stream_io.
// master = the fft_stream_io block, slave = its surroundings.
interface fft_stream_io_if #(
   parameter int LOG2N = 5,
   parameter int DW    = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             out_last;
   logic             start_fft;
   logic             fft_done;
   logic             mem_we;
   logic [LOG2N-1:0] mem_waddr;
   logic [DW-1:0]    mem_wdata;
   logic [LOG2N-1:0] mem_raddr;
   logic [DW-1:0]    mem_rdata;
   logic             busy;

   modport master (
      input  in_valid, in_data, out_ready, fft_done, mem_rdata,
      output in_ready, out_valid, out_data, out_last, start_fft,
             mem_we, mem_waddr, mem_wdata, mem_raddr, busy
   );

   modport slave (
      output in_valid, in_data, out_ready, fft_done, mem_rdata,
      input  in_ready, out_valid, out_data, out_last, start_fft,
             mem_we, mem_waddr, mem_wdata, mem_raddr, busy
   );
endinterface

// File: rtl/fft_stream_io.sv
// Host-side loader/unloader for the radix-2 FFT core: bit-reversed load, start, wait, natural-order unload.
// Define FFT_STREAM_IO_SCALE_EN to shift both output halves right by LOG2N (1/N normalisation).
module fft_stream_io #(
   parameter int LOG2N = 5,
   parameter int DW    = 64
) (
   input logic             clk,
   input logic             rst,
   fft_stream_io_if.master io
);
   localparam int HW = DW / 2;
   localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};
   localparam logic [LOG2N-1:0] ONE      = {{(LOG2N-1){1'b0}}, 1'b1};
   localparam logic [LOG2N:0]   RONE     = {{LOG2N{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_START  = 2'd1,
      S_WAIT   = 2'd2,
      S_UNLOAD = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [LOG2N-1:0] cnt_r, cnt_s, ocnt_r;
   logic [LOG2N:0]   rcnt_r;
   logic [1:0]       occ_r;
   logic             inflight_r;
   logic [DW-1:0]    buf0_r, buf1_r;
   logic             in_ready_r, start_fft_r, busy_r, busy_s;
   logic             load_fire_s, out_valid_s, out_last_s, pop_s, push_s, issue_s, frame_end_s;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      r = {LOG2N{1'b0}};
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   function automatic logic [DW-1:0] scale_out(input logic [DW-1:0] d);
`ifdef FFT_STREAM_IO_SCALE_EN
      logic signed [HW-1:0] re, im;
      re = $signed(d[DW-1:HW]) >>> LOG2N;
      im = $signed(d[HW-1:0]) >>> LOG2N;
      return {re, im};
`else
      return d;
`endif
   endfunction

   assign load_fire_s = io.in_valid & in_ready_r;
   assign out_valid_s = (occ_r != 2'd0);
   assign out_last_s  = out_valid_s && (ocnt_r == LAST_IDX);
   assign pop_s       = out_valid_s & io.out_ready;
   assign push_s      = inflight_r;
   assign frame_end_s = pop_s & out_last_s;
   // A pop in this cycle frees a slot, which keeps the unload bubble-free at full rate.
   assign issue_s     = (state_r == S_UNLOAD) && !rcnt_r[LOG2N] &&
                        (({1'b0, occ_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));

   assign io.in_ready  = in_ready_r;
   assign io.start_fft = start_fft_r;
   assign io.busy      = busy_r;
   assign io.mem_we    = load_fire_s;
   assign io.mem_waddr = bitrev(cnt_r);
   assign io.mem_wdata = io.in_data;
   assign io.mem_raddr = (state_r == S_UNLOAD) ? rcnt_r[LOG2N-1:0] : {LOG2N{1'b0}};
   assign io.out_valid = out_valid_s;
   assign io.out_last  = out_last_s;
   assign io.out_data  = scale_out(buf0_r);

   // Next-state and load-counter logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         S_LOAD: begin
            if (load_fire_s) begin
               cnt_s = cnt_r + ONE;
               if (cnt_r == LAST_IDX) state_s = S_START;
               else                   state_s = S_LOAD;
            end else begin
               state_s = S_LOAD;
            end
         end
         S_START: state_s = S_WAIT;
         S_WAIT: begin
            if (io.fft_done) state_s = S_UNLOAD;
            else             state_s = S_WAIT;
         end
         S_UNLOAD: begin
            if (frame_end_s) state_s = S_LOAD;
            else             state_s = S_UNLOAD;
         end
         default: begin
            state_s = S_LOAD;
            cnt_s   = {LOG2N{1'b0}};
         end
      endcase
      busy_s = !((state_s == S_LOAD) && (cnt_s == {LOG2N{1'b0}}));
   end

   // State register and registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_LOAD;
         cnt_r       <= {LOG2N{1'b0}};
         in_ready_r  <= 1'b0;
         start_fft_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         in_ready_r  <= (state_s == S_LOAD);
         start_fft_r <= (state_s == S_START);
         busy_r      <= busy_s;
      end
   end

   // Read-issue and output-beat counters for the unload phase.
   always_ff @(posedge clk) begin
      if (rst || frame_end_s) begin
         rcnt_r <= {(LOG2N+1){1'b0}};
         ocnt_r <= {LOG2N{1'b0}};
      end else begin
         if (issue_s) rcnt_r <= rcnt_r + RONE;
         if (pop_s)   ocnt_r <= ocnt_r + ONE;
      end
   end

   // Two-entry skid buffer; buf0_r is always the head presented on out_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_r <= 1'b0;
         occ_r      <= 2'd0;
         buf0_r     <= {DW{1'b0}};
         buf1_r     <= {DW{1'b0}};
      end else begin
         inflight_r <= issue_s;
         case ({push_s, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  buf0_r <= io.mem_rdata;
                  occ_r  <= 2'd1;
               end else begin
                  buf1_r <= io.mem_rdata;
                  occ_r  <= 2'd2;
               end
            end
            2'b01: begin
               buf0_r <= buf1_r;
               occ_r  <= occ_r - 2'd1;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  buf0_r <= io.mem_rdata;
               end else begin
                  buf0_r <= buf1_r;
                  buf1_r <= io.mem_rdata;
               end
            end
            default: occ_r <= occ_r;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_stream_io.sv
// Scoreboard bench for fft_stream_io with a behavioural 1-cycle-latency data memory.
module tb_fft_stream_io;
   logic clk;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   writes_seen  = 0;
   bit   preload      = 1'b0;

   logic [63:0]  mem_model [0:31];
   logic [63:0]  exp_q [$];
   logic [68:0]  wq [$];

   fft_stream_io_if #(.LOG2N(5), .DW(64)) bus ();
   fft_stream_io #(.LOG2N(5), .DW(64)) dut (.clk(clk), .rst(rst), .io(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < 32; k++) mem_model[k] <= {32'(k), ~32'(k)};
      end else if (bus.mem_we) begin
         mem_model[bus.mem_waddr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= mem_model[bus.mem_raddr];
      if (bus.mem_we) writes_seen <= writes_seen + 1;
   end

   function automatic logic [4:0] bitrev_tb(input int i);
      logic [4:0] v;
      v = i[4:0];
      return {v[0], v[1], v[2], v[3], v[4]};
   endfunction

   function automatic logic [63:0] frame_word(input int base, input int i);
      logic [31:0] a, b;
      a = 32'(base + i);
      b = 32'hA5A5_0000 ^ 32'(i);
      return {a, b};
   endfunction

   function automatic logic [63:0] exp_out(input logic [63:0] w);
`ifdef FFT_STREAM_IO_SCALE_EN
      return {{5{w[63]}}, w[63:37], {5{w[31]}}, w[31:5]};
`else
      return w;
`endif
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.out_ready = 1'b0; bus.fft_done = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      tests_run++; if (bus.in_ready !== 1'b0)  begin tests_failed++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
      tests_run++; if (bus.out_last !== 1'b0)  begin tests_failed++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
      tests_run++; if (bus.start_fft !== 1'b0) begin tests_failed++; $display("FAIL rst_start got=%b exp=0", bus.start_fft); end
      tests_run++; if (bus.mem_we !== 1'b0)    begin tests_failed++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
      tests_run++; if (bus.busy !== 1'b0)      begin tests_failed++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      tests_run++; if (bus.out_data !== 64'd0) begin tests_failed++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
      rst = 1'b0;
      @(negedge clk); #1;
      tests_run++; if (bus.in_ready !== 1'b1)  begin tests_failed++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_load(input int base, input int stray_idx);
      int          w0;
      logic [63:0] d;
      logic [68:0] e;
      w0 = writes_seen;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         d = frame_word(base, i);
         bus.in_valid = 1'b1; bus.in_data = d; bus.fft_done = (i == stray_idx);
         wq.push_back({bitrev_tb(i), d});
         #1;
         e = wq.pop_front();
         tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL load_in_ready beat=%0d got=%b exp=1", i, bus.in_ready); end
         tests_run++;
         if (bus.mem_we !== 1'b1 || {bus.mem_waddr, bus.mem_wdata} !== e) begin
            tests_failed++;
            $display("FAIL load_write beat=%0d got we=%b addr=%0d data=%h exp addr=%0d data=%h",
                     i, bus.mem_we, bus.mem_waddr, bus.mem_wdata, e[68:64], e[63:0]);
         end
      end
      // START cycle: further input ignored, optional overlapping fft_done ignored.
      @(negedge clk);
      bus.in_data = 64'hDEAD_BEEF_0BAD_F00D; bus.fft_done = (stray_idx >= 0);
      #1;
      tests_run++; if (bus.in_ready !== 1'b0)  begin tests_failed++; $display("FAIL start_in_ready got=%b exp=0", bus.in_ready); end
      tests_run++; if (bus.start_fft !== 1'b1) begin tests_failed++; $display("FAIL start_pulse got=%b exp=1", bus.start_fft); end
      tests_run++; if (bus.mem_we !== 1'b0)    begin tests_failed++; $display("FAIL start_mem_we got=%b exp=0", bus.mem_we); end
      tests_run++; if (bus.busy !== 1'b1)      begin tests_failed++; $display("FAIL start_busy got=%b exp=1", bus.busy); end
      @(negedge clk);
      bus.in_valid = 1'b0; bus.fft_done = 1'b0;
      #1;
      tests_run++; if (bus.start_fft !== 1'b0) begin tests_failed++; $display("FAIL start_single got=%b exp=0", bus.start_fft); end
      tests_run++; if (writes_seen - w0 !== 32) begin tests_failed++; $display("FAIL load_write_count got=%0d exp=32", writes_seen - w0); end
   endtask

   task automatic test_wait(input bit do_preload, input int base);
      int errs;
      errs = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         bus.fft_done = 1'b0; bus.out_ready = 1'b0; preload = do_preload && (c == 0);
         #1;
         if (bus.out_valid !== 1'b0 || bus.mem_we !== 1'b0 || bus.start_fft !== 1'b0 ||
             bus.busy !== 1'b1 || bus.mem_raddr !== 5'd0) errs++;
      end
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL wait_hold got=%0d bad cycles exp=0", errs); end
      exp_q.delete();
      for (int k = 0; k < 32; k++) begin
         if (do_preload) exp_q.push_back(exp_out({32'(k), ~32'(k)}));
         else            exp_q.push_back(exp_out(frame_word(base, int'(bitrev_tb(k)))));
      end
      @(negedge clk); bus.fft_done = 1'b1;
      @(negedge clk); bus.fft_done = 1'b0; #1;
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL unload_early1 got=%b exp=0", bus.out_valid); end
      @(negedge clk); #1;
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL unload_early2 got=%b exp=0", bus.out_valid); end
      @(negedge clk); #1;
      tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL unload_first_valid got=%b exp=1", bus.out_valid); end
      tests_run++; if (bus.out_data !== exp_q[0]) begin tests_failed++; $display("FAIL unload_first_data got=%h exp=%h", bus.out_data, exp_q[0]); end
   endtask

   task automatic test_unload(input int pat_mode, input int stop_after);
      int          popped, cyc;
      bit          hold, done;
      logic [63:0] held, e;
      popped = 0; hold = 1'b0; done = 1'b0; held = 64'd0;
      for (cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         bus.out_ready = (pat_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         #1;
         if (hold) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
               tests_failed++;
               $display("FAIL unload_stable got valid=%b data=%h exp valid=1 data=%h", bus.out_valid, bus.out_data, held);
            end
         end
         hold = bus.out_valid && !bus.out_ready;
         held = bus.out_data;
         if (bus.out_valid && bus.out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++; $display("FAIL unload_extra got=%h exp=none", bus.out_data);
               done = 1'b1;
            end else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin tests_failed++; $display("FAIL unload_data k=%0d got=%h exp=%h", popped, bus.out_data, e); end
               tests_run++;
               if (bus.out_last !== (exp_q.size() == 0)) begin
                  tests_failed++; $display("FAIL unload_last k=%0d got=%b exp=%b", popped, bus.out_last, exp_q.size() == 0);
               end
               popped++;
               if (exp_q.size() == 0 || popped == stop_after) done = 1'b1;
            end
         end
      end
      tests_run++; if (!done) begin tests_failed++; $display("FAIL unload_timeout got=%0d beats exp=%0d", popped, (stop_after == 0) ? 32 : stop_after); end
      if (stop_after == 0) begin
         if (pat_mode == 0) begin
            tests_run++; if (cyc !== 32) begin tests_failed++; $display("FAIL unload_rate got=%0d cycles exp=32", cyc); end
         end
         @(negedge clk); bus.out_ready = 1'b0; #1;
         tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL end_out_valid got=%b exp=0", bus.out_valid); end
         tests_run++; if (bus.in_ready !== 1'b1)  begin tests_failed++; $display("FAIL end_in_ready got=%b exp=1", bus.in_ready); end
         tests_run++; if (bus.busy !== 1'b0)      begin tests_failed++; $display("FAIL end_busy got=%b exp=0", bus.busy); end
      end
   endtask

   task automatic test_normal_frame;
      test_load(100, -1);
      test_wait(1'b0, 100);
      test_unload(0, 0);
   endtask

   task automatic test_stray_done_backpressure;
      test_load(200, 10);
      test_wait(1'b1, 0);
      test_unload(1, 0);
   endtask

   task automatic test_reset_midframe;
      test_load(300, -1);
      test_wait(1'b0, 300);
      test_unload(0, 7);
      @(negedge clk);
      rst = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk); #1;
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_out_valid got=%b exp=0", bus.out_valid); end
      tests_run++; if (bus.busy !== 1'b0)      begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
      tests_run++; if (bus.start_fft !== 1'b0) begin tests_failed++; $display("FAIL abort_start got=%b exp=0", bus.start_fft); end
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk); #1;
      tests_run++; if (bus.in_ready !== 1'b1)  begin tests_failed++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_out_valid2 got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back;
      test_load(400, -1);
      test_wait(1'b0, 400);
      test_unload(1, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_normal_frame;
      test_stray_done_backpressure;
      test_reset_midframe;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
